// File: rtl/alu32_pkg.sv
// Shared definitions for the 32-bit ALU and the arbiter that time-shares it
// between two requesters.
package alu32_pkg;

  localparam int ALU_OP_W = 3;
  localparam int DATA_W   = 32;
  localparam int SET_W    = 4;

  localparam logic [ALU_OP_W-1:0] ALU_AND  = 3'd0;
  localparam logic [ALU_OP_W-1:0] ALU_OR   = 3'd1;
  localparam logic [ALU_OP_W-1:0] ALU_XOR  = 3'd2;
  localparam logic [ALU_OP_W-1:0] ALU_NAND = 3'd3;
  localparam logic [ALU_OP_W-1:0] ALU_NOR  = 3'd4;
  localparam logic [ALU_OP_W-1:0] ALU_XNOR = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant; purely combinational from the valids and the
// priority pointer held by the caller.
module rr_arb2 (
  input  logic valid0,
  input  logic valid1,
  input  logic ptr,
  output logic gnt_valid,
  output logic gnt
);

  // pick the pointed-to requester only when both compete
  always_comb begin
    gnt_valid = valid0 | valid1;
    if (valid0 && valid1) begin
      gnt = ptr;
    end else if (valid1) begin
      gnt = 1'b1;
    end else begin
      gnt = 1'b0;
    end
  end

endmodule

// File: rtl/alu32_arbiter.sv
// Serialises two requesters onto one combinational ALU: accept, hold registered
// operands for SETTLE cycles, capture alu_y, then return it to the owner.
module alu32_arbiter
  import alu32_pkg::*;
#(
  parameter int SETTLE = 1,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [ALU_OP_W-1:0] req0_op,
  input  logic [DATA_W-1:0]   req0_a,
  input  logic [DATA_W-1:0]   req0_b,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [ALU_OP_W-1:0] req1_op,
  input  logic [DATA_W-1:0]   req1_a,
  input  logic [DATA_W-1:0]   req1_b,
  output logic                rsp0_valid,
  input  logic                rsp0_ready,
  output logic [DATA_W-1:0]   rsp0_y,
  output logic                rsp1_valid,
  input  logic                rsp1_ready,
  output logic [DATA_W-1:0]   rsp1_y,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  input  logic [DATA_W-1:0]   alu_y,
  output logic                busy,
  output logic [CNT_W-1:0]    op_count
);

  localparam logic [SET_W-1:0] SETTLE_LD = SET_W'(SETTLE - 1);

  state_e                state_q, state_d;
  logic                  ptr_q, ptr_d;
  logic                  owner_q, owner_d;
  logic [SET_W-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]      op_count_q, op_count_d;
  logic [ALU_OP_W-1:0]   alu_op_q, alu_op_d;
  logic [DATA_W-1:0]     alu_a_q, alu_a_d;
  logic [DATA_W-1:0]     alu_b_q, alu_b_d;
  logic [DATA_W-1:0]     res_q, res_d;
  logic                  gnt_valid;
  logic                  gnt;
  logic                  rsp_take;

  rr_arb2 u_arb (
    .valid0    (req0_valid),
    .valid1    (req1_valid),
    .ptr       (ptr_q),
    .gnt_valid (gnt_valid),
    .gnt       (gnt)
  );

  assign rsp_take = owner_q ? rsp1_ready : rsp0_ready;

  // next-state, operand capture and completion bookkeeping
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    op_count_d = op_count_q;
    alu_op_d   = alu_op_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    res_d      = res_q;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          alu_op_d = gnt ? req1_op : req0_op;
          alu_a_d  = gnt ? req1_a  : req0_a;
          alu_b_d  = gnt ? req1_b  : req0_b;
          owner_d  = gnt;
          cnt_d    = SETTLE_LD;
          state_d  = EXEC;
        end else begin
          state_d  = IDLE;
        end
      end
      EXEC: begin
        if (cnt_q == {SET_W{1'b0}}) begin
          res_d   = alu_y;
          state_d = RESP;
        end else begin
          cnt_d   = cnt_q - {{(SET_W-1){1'b0}}, 1'b1};
        end
      end
      RESP: begin
        // ptr flips away from the owner so a waiting peer wins next
        if (rsp_take) begin
          op_count_d = op_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
          ptr_d      = ~owner_q;
          state_d    = IDLE;
        end else begin
          state_d    = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      ptr_q      <= 1'b0;
      owner_q    <= 1'b0;
      cnt_q      <= {SET_W{1'b0}};
      op_count_q <= {CNT_W{1'b0}};
      alu_op_q   <= {ALU_OP_W{1'b0}};
      alu_a_q    <= {DATA_W{1'b0}};
      alu_b_q    <= {DATA_W{1'b0}};
      res_q      <= {DATA_W{1'b0}};
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      op_count_q <= op_count_d;
      alu_op_q   <= alu_op_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      res_q      <= res_d;
    end
  end

  assign req0_ready = (state_q == IDLE) && gnt_valid && !gnt;
  assign req1_ready = (state_q == IDLE) && gnt_valid &&  gnt;
  assign rsp0_valid = (state_q == RESP) && !owner_q;
  assign rsp1_valid = (state_q == RESP) &&  owner_q;
  assign rsp0_y     = rsp0_valid ? res_q : {DATA_W{1'b0}};
  assign rsp1_y     = rsp1_valid ? res_q : {DATA_W{1'b0}};
  assign alu_op     = alu_op_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign busy       = (state_q != IDLE);
  assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu32_arbiter.sv
// Self-checking bench: dut0 uses SETTLE=1/CNT_W=16, dut1 uses SETTLE=3/CNT_W=4;
// responses are checked against a scoreboard queue filled at acceptance.
module tb_alu32_arbiter;
  import alu32_pkg::*;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
  } vec_t;

  typedef struct {
    int          d;
    int          r;
    logic [31:0] y;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rq_valid [2][2];
  logic        rq_ready [2][2];
  logic [2:0]  rq_op    [2][2];
  logic [31:0] rq_a     [2][2];
  logic [31:0] rq_b     [2][2];
  logic        rs_valid [2][2];
  logic        rs_ready [2][2];
  logic [31:0] rs_y     [2][2];
  logic [2:0]  alu_op   [2];
  logic [31:0] alu_a    [2];
  logic [31:0] alu_b    [2];
  logic [31:0] alu_y    [2];
  logic [31:0] y_xor    [2];
  logic        busy     [2];
  logic [15:0] cnt0;
  logic [3:0]  cnt1;

  int   n_chk = 0;
  int   n_pass = 0;
  exp_t sbq[$];
  int   glog[$];
  vec_t vt[6];
  vec_t cv[2][2];

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_NAND: return ~(a & b);
      ALU_NOR:  return ~(a | b);
      ALU_XNOR: return ~(a ^ b);
      default:  return 32'd0;
    endcase
  endfunction

  assign alu_y[0] = alu_model(alu_op[0], alu_a[0], alu_b[0]) ^ y_xor[0];
  assign alu_y[1] = alu_model(alu_op[1], alu_a[1], alu_b[1]) ^ y_xor[1];

  alu32_arbiter #(.SETTLE(1), .CNT_W(16)) dut0 (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(rq_valid[0][0]), .req0_ready(rq_ready[0][0]), .req0_op(rq_op[0][0]),
    .req0_a(rq_a[0][0]), .req0_b(rq_b[0][0]),
    .req1_valid(rq_valid[0][1]), .req1_ready(rq_ready[0][1]), .req1_op(rq_op[0][1]),
    .req1_a(rq_a[0][1]), .req1_b(rq_b[0][1]),
    .rsp0_valid(rs_valid[0][0]), .rsp0_ready(rs_ready[0][0]), .rsp0_y(rs_y[0][0]),
    .rsp1_valid(rs_valid[0][1]), .rsp1_ready(rs_ready[0][1]), .rsp1_y(rs_y[0][1]),
    .alu_op(alu_op[0]), .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_y(alu_y[0]),
    .busy(busy[0]), .op_count(cnt0)
  );

  alu32_arbiter #(.SETTLE(3), .CNT_W(4)) dut1 (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(rq_valid[1][0]), .req0_ready(rq_ready[1][0]), .req0_op(rq_op[1][0]),
    .req0_a(rq_a[1][0]), .req0_b(rq_b[1][0]),
    .req1_valid(rq_valid[1][1]), .req1_ready(rq_ready[1][1]), .req1_op(rq_op[1][1]),
    .req1_a(rq_a[1][1]), .req1_b(rq_b[1][1]),
    .rsp0_valid(rs_valid[1][0]), .rsp0_ready(rs_ready[1][0]), .rsp0_y(rs_y[1][0]),
    .rsp1_valid(rs_valid[1][1]), .rsp1_ready(rs_ready[1][1]), .rsp1_y(rs_y[1][1]),
    .alu_op(alu_op[1]), .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_y(alu_y[1]),
    .busy(busy[1]), .op_count(cnt1)
  );

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endfunction

  // response monitor: every handshake pops the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      for (int r = 0; r < 2; r++) begin
        if (reset_n && rs_valid[d][r]) begin
          chk("other_rsp_valid", 32'(rs_valid[d][1-r]), 32'd0);
          chk("other_rsp_y", rs_y[d][1-r], 32'd0);
          if (rs_ready[d][r]) begin
            if (sbq.size() == 0) begin
              chk("unexpected_rsp", 32'(sbq.size()), 32'd1);
            end else begin
              e = sbq.pop_front();
              chk("rsp_owner", 32'(d * 2 + r), 32'(e.d * 2 + e.r));
              chk("rsp_y", rs_y[d][r], e.y);
            end
          end
        end
      end
    end
  end

  task automatic hold_reset();
    reset_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      y_xor[d] = 32'd0;
      for (int r = 0; r < 2; r++) begin
        rq_valid[d][r] = 1'b0;
        rq_op[d][r] = 3'd0;
        rq_a[d][r] = 32'd0;
        rq_b[d][r] = 32'd0;
        rs_ready[d][r] = 1'b1;
      end
    end
    sbq.delete();
    glog.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int d, input int r, input vec_t v, input bit keep, output int waits);
    exp_t e;
    rq_op[d][r] = v.op;
    rq_a[d][r] = v.a;
    rq_b[d][r] = v.b;
    rq_valid[d][r] = 1'b1;
    waits = 0;
    @(negedge clk);
    while (!rq_ready[d][r] && waits < 60) begin
      waits++;
      @(negedge clk);
    end
    if (!rq_ready[d][r]) begin
      chk("accept_timeout", 32'(rq_ready[d][r]), 32'd1);
    end else begin
      e.d = d; e.r = r; e.y = v.y;
      sbq.push_back(e);
      glog.push_back(r);
    end
    @(posedge clk);
    #1;
    if (!keep) rq_valid[d][r] = 1'b0;
  endtask

  task automatic wait_rsp(input int d, input int r, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rs_valid[d][r] && n < 60);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sbq.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(sbq.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time %0t, expected completion earlier", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    int n;
    int seen;
    vt[0] = '{ALU_XOR,  32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F};
    vt[1] = '{ALU_AND,  32'hF0F0F0F0, 32'h3C3C3C3C, 32'h30303030};
    vt[2] = '{ALU_OR,   32'h12340000, 32'h00005678, 32'h12345678};
    vt[3] = '{ALU_NAND, 32'hFFFFFFFF, 32'h0000FFFF, 32'hFFFF0000};
    vt[4] = '{ALU_NOR,  32'h00000000, 32'h00000000, 32'hFFFFFFFF};
    vt[5] = '{ALU_XNOR, 32'hAAAAAAAA, 32'h55555555, 32'h00000000};
    cv[0][0] = '{ALU_OR,  32'h00FF0000, 32'h000000FF, 32'h00FF00FF};
    cv[0][1] = '{ALU_AND, 32'hFFFF0000, 32'h12345678, 32'h12340000};
    cv[1][0] = '{ALU_XOR, 32'h0000FFFF, 32'hFFFFFFFF, 32'hFFFF0000};
    cv[1][1] = '{ALU_NOR, 32'hF0F0F0F0, 32'h0F0F0F00, 32'h0000000F};

    // reset values
    hold_reset();
    for (int d = 0; d < 2; d++) begin
      chk("rst_busy", 32'(busy[d]), 32'd0);
      chk("rst_alu_op", 32'(alu_op[d]), 32'd0);
      chk("rst_alu_a", alu_a[d], 32'd0);
      chk("rst_alu_b", alu_b[d], 32'd0);
      for (int r = 0; r < 2; r++) begin
        chk("rst_rsp_valid", 32'(rs_valid[d][r]), 32'd0);
        chk("rst_req_ready", 32'(rq_ready[d][r]), 32'd0);
      end
    end
    chk("rst_cnt0", 32'(cnt0), 32'd0);
    chk("rst_cnt1", 32'(cnt1), 32'd0);

    // table of single requests, SETTLE=1
    release_reset();
    for (int i = 0; i < 6; i++) begin
      issue(0, i % 2, vt[i], 1'b0, w);
      chk("alu_op_pass", 32'(alu_op[0]), 32'(vt[i].op));
      chk("alu_a_reg", alu_a[0], vt[i].a);
      chk("alu_b_reg", alu_b[0], vt[i].b);
      wait_rsp(0, i % 2, n);
      chk("latency_s1", 32'(n), 32'd2);
      wait_drain();
      chk("idle_busy", 32'(busy[0]), 32'd0);
      chk("op_count", 32'(cnt0), 32'(i + 1));
    end
    chk("alu_a_hold_idle", alu_a[0], vt[5].a);

    // contention: both valid, grants must alternate from ptr=0
    hold_reset();
    release_reset();
    fork
      begin
        for (int k = 0; k < 2; k++) issue(0, 0, cv[0][k], k == 0, w);
      end
      begin
        for (int k = 0; k < 2; k++) issue(0, 1, cv[1][k], k == 0, w);
      end
    join
    wait_drain();
    chk("grant_count", 32'(glog.size()), 32'd4);
    for (int i = 0; i < glog.size(); i++) chk("grant_order", 32'(glog[i]), 32'(i % 2));
    chk("op_count_4", 32'(cnt0), 32'd4);

    // backpressure on rsp1 with req0 waiting
    hold_reset();
    release_reset();
    rs_ready[0][1] = 1'b0;
    issue(0, 1, vt[1], 1'b0, w);
    rq_op[0][0] = vt[2].op;
    rq_a[0][0] = vt[2].a;
    rq_b[0][0] = vt[2].b;
    rq_valid[0][0] = 1'b1;
    wait_rsp(0, 1, n);
    chk("bp_latency", 32'(n), 32'd2);
    for (int k = 0; k < 5; k++) begin
      chk("bp_rsp_valid", 32'(rs_valid[0][1]), 32'd1);
      chk("bp_rsp_y", rs_y[0][1], vt[1].y);
      chk("bp_req0_ready", 32'(rq_ready[0][0]), 32'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    rs_ready[0][1] = 1'b1;
    issue(0, 0, vt[2], 1'b0, w);
    chk("bp_accept_next", 32'(w), 32'd1);
    wait_drain();
    chk("bp_op_count", 32'(cnt0), 32'd2);

    // SETTLE=3: operands held, late alu_y change ignored
    hold_reset();
    release_reset();
    rs_ready[1][0] = 1'b0;
    issue(1, 0, vt[0], 1'b0, w);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("s3_alu_a", alu_a[1], vt[0].a);
      chk("s3_alu_b", alu_b[1], vt[0].b);
      chk("s3_no_rsp", 32'(rs_valid[1][0]), 32'd0);
    end
    @(negedge clk);
    chk("s3_rsp_at_t4", 32'(rs_valid[1][0]), 32'd1);
    @(posedge clk);
    #1;
    y_xor[1] = 32'hDEADBEEF;
    @(negedge clk);
    chk("s3_y_stable", rs_y[1][0], vt[0].y);
    @(posedge clk);
    #1;
    rs_ready[1][0] = 1'b1;
    wait_drain();
    y_xor[1] = 32'd0;
    chk("s3_op_count", 32'(cnt1), 32'd1);

    // asynchronous reset in the middle of EXEC
    issue(1, 1, vt[3], 1'b0, w);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_busy", 32'(busy[1]), 32'd0);
    chk("mid_alu_op", 32'(alu_op[1]), 32'd0);
    chk("mid_alu_a", alu_a[1], 32'd0);
    chk("mid_alu_b", alu_b[1], 32'd0);
    chk("mid_cnt", 32'(cnt1), 32'd0);
    chk("mid_rsp_valid", 32'(rs_valid[1][0] | rs_valid[1][1]), 32'd0);
    sbq.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (rs_valid[1][0] || rs_valid[1][1] || busy[1]) seen++;
    end
    chk("mid_no_rsp", 32'(seen), 32'd0);

    // 4-bit counter wraps 15 -> 0
    hold_reset();
    release_reset();
    for (int i = 0; i < 16; i++) begin
      issue(1, i % 2, vt[i % 6], 1'b0, w);
      wait_drain();
      chk("wrap_count", 32'(cnt1), 32'((i + 1) % 16));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
